alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit implementing the RV64M funct3 operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the combinational ALU in the execute stage.
- Control logic starts it on an M-type instruction, stalls on busy, and captures res when done pulses.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle, with fast paths for the RISC-V divide special cases.

Parameters:
SIZE, 64, operand/result width in bits; must be even and >= 8 (8 used for exhaustive bench runs).
CNT_W, $clog2(SIZE)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high; one clock; clears all state.
start  input  1  request; accepted only in IDLE.
flush  input  1  abort the current operation (pipeline flush).
s1  input  SIZE  rs1 operand; sampled on accept.
s2  input  SIZE  rs2 operand; sampled on accept.
funct3  input  3  operation select; sampled on accept.
busy  output  1  high in CALC and DONE.
done  output  1  one-cycle pulse; res is valid in that cycle.
res  output  SIZE  registered result; holds until the next accepted start.
alu_flags  output  4  {div_by_zero, div_overflow, msb(res), zero(res)}; registered with res.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, res=0, alu_flags=4'b0001 (zero flag set, since res=0); counter and operand registers cleared. Reset wins over start and flush in the same cycle.
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - Latch s1, s2 and funct3; counter=0.
  - Go to CALC, or directly to DONE on a special case (below).
- start while busy is ignored. Upstream must hold the instruction until done.
- CALC:
  - One bit per cycle for SIZE cycles.
  - When counter reaches SIZE-1, the next state is DONE and res/alu_flags load on that edge.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency, normal path: start accepted at edge 0, done high in cycle SIZE+1. SIZE=64 gives done in cycle 65.
- Latency, fast path: done high in cycle 1.
- Back-to-back: start may be asserted in the DONE cycle but is not accepted. Earliest next accept is the cycle after done.
- flush in CALC or DONE: back to IDLE on the next edge, no done pulse, res and alu_flags unchanged. flush in IDLE has no effect. flush beats a simultaneous start.
- Multiply:
  - MUL / MULHU / MULH / MULHSU: operands sign- or zero-extended per funct3 (MULH both signed, MULHSU s1 signed and s2 unsigned, MULHU both unsigned).
  - Product accumulated as 2*SIZE bits, computed on magnitudes; the product sign is applied at completion.
  - MUL returns product[SIZE-1:0]; MULH* return product[2*SIZE-1:SIZE].
- Divide:
  - DIV and REM use signed magnitude with truncation toward zero.
  - Remainder takes the sign of the dividend.
- Special cases (fast path, no CALC):
  - s2 == 0: DIV/DIVU give all ones; REM/REMU give s1; div_by_zero=1.
  - Signed overflow (DIV/REM only), s1 = 1<<(SIZE-1) and s2 = all ones: DIV gives s1, REM gives 0, div_overflow=1.
- div_by_zero and div_overflow are 0 for every other result. msb and zero always track the final res.
- Operands may change after accept without affecting the result.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 localparams: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - State encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
- One sub-module, seq_divider:
  - Restoring divide step on unsigned magnitudes: remainder/quotient registers and one step per cycle when enabled.
  - Top level owns the FSM, counter, sign handling, the multiplier datapath and the special-case detection.

Test Plan:
- Reset held 2 cycles, then released -> busy=0, done=0, res=0, alu_flags=4'b0001. start together with reset -> still IDLE afterwards.
- MUL, s1=7, s2=-3 (SIZE=64) -> done in cycle 65, res=0xFFFFFFFFFFFFFFEB, flags=4'b0010. MULHU, s1=s2=all ones -> res=0xFFFFFFFFFFFFFFFE.
- DIV, s1=-7, s2=2 -> res=-3. REM with the same operands -> res=-1 (0xFF..FF). DIVU, s1=100, s2=7 -> res=14, flags=4'b0000.
- DIVU, s1=5, s2=0 -> done in cycle 1, res=all ones, flags=4'b1010. REMU with the same operands -> res=5, flags=4'b1000.
- DIV, s1=0x8000000000000000, s2=-1 -> done in cycle 1, res=0x8000000000000000, flags=4'b0110. REM with the same operands -> res=0, flags=4'b0101.
- Control sequencing:
  - MUL started, flush at cycle 10 -> IDLE at cycle 11, no done, res keeps its previous value.
  - A second start during CALC is ignored.
  - A new start the cycle after done is accepted.
- Random regression at SIZE=8: compare every funct3 result against a reference model.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV64M multiply/divide unit: funct3 opcodes,
// FSM states and operand-signedness decode.
package muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic s1_is_signed(input logic [2:0] f3);
        return (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
    endfunction

    function automatic logic s2_is_signed(input logic [2:0] f3);
        return (f3 == MULH) || (f3 == DIV) || (f3 == REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_divider.sv
// Restoring divider on unsigned magnitudes, one quotient bit per enabled step.
// Next-step values are exposed so the caller can capture the final bit on the same edge; no backpressure.
module seq_divider #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [SIZE-1:0] dividend_i,
    input  logic [SIZE-1:0] divisor_i,
    output logic [SIZE-1:0] quo_nxt_o,
    output logic [SIZE-1:0] rem_nxt_o
);
    logic [SIZE-1:0] rem_q, quo_q, dvs_q;
    logic [SIZE:0]   shifted, diff;

    // Partial remainder is always below the divisor, so the shifted value fits in SIZE+1 bits.
    always_comb begin
        shifted   = {rem_q, quo_q[SIZE-1]};
        diff      = shifted - {1'b0, dvs_q};
        quo_nxt_o = {quo_q[SIZE-2:0], ~diff[SIZE]};
        rem_nxt_o = diff[SIZE] ? shifted[SIZE-1:0] : diff[SIZE-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_nxt_o;
            quo_q <= quo_nxt_o;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV64M mul/div: SIZE+1 cycles to done, 1 cycle for divide special cases.
// start is only taken in IDLE (upstream holds until done); flush aborts without a done pulse.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [SIZE-1:0] s1,
    input  logic [SIZE-1:0] s2,
    input  logic [2:0]      funct3,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] res,
    output logic [3:0]      alu_flags
);
    localparam int CNT_W = $clog2(SIZE) + 1;
    localparam logic [SIZE-1:0] MIN_NEG = {1'b1, {(SIZE-1){1'b0}}};

    state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic              neg_q, rneg_q;
    logic [2*SIZE-1:0] mcand_q, prod_q;
    logic [SIZE-1:0]   mplr_q;
    logic [SIZE-1:0]   res_q, res_d;
    logic [3:0]        flags_q, flags_d;

    logic              a_neg, b_neg, dbz, ovf, special, accept, finish;
    logic [SIZE-1:0]   a_mag, b_mag, fast_res, calc_res;
    logic [SIZE-1:0]   quo_nxt, rem_nxt, quo_fin, rem_fin;
    logic [2*SIZE-1:0] prod_nxt, prod_fin;

    always_comb begin
        a_neg    = s1_is_signed(funct3) & s1[SIZE-1];
        b_neg    = s2_is_signed(funct3) & s2[SIZE-1];
        a_mag    = a_neg ? -s1 : s1;
        b_mag    = b_neg ? -s2 : s2;
        dbz      = funct3[2] && (s2 == '0);
        ovf      = ((funct3 == DIV) || (funct3 == REM)) && (s1 == MIN_NEG) && (s2 == '1);
        special  = dbz | ovf;
        // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
        fast_res = funct3[1] ? (dbz ? s1 : '0) : (dbz ? '1 : s1);
        accept   = (state_q == IDLE) && start && !flush;
        finish   = (state_q == CALC) && (cnt_q == CNT_W'(SIZE-1)) && !flush;
    end

    seq_divider #(.SIZE(SIZE)) u_div (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .step_i     (state_q == CALC),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quo_nxt_o  (quo_nxt),
        .rem_nxt_o  (rem_nxt)
    );

    // Result is assembled from the final step's next values so it loads on the CALC->DONE edge.
    always_comb begin
        prod_nxt = prod_q + (mplr_q[0] ? mcand_q : '0);
        prod_fin = neg_q ? -prod_nxt : prod_nxt;
        quo_fin  = neg_q ? -quo_nxt : quo_nxt;
        rem_fin  = rneg_q ? -rem_nxt : rem_nxt;
        case (f3_q)
            MUL:                 calc_res = prod_fin[SIZE-1:0];
            MULH, MULHSU, MULHU: calc_res = prod_fin[2*SIZE-1:SIZE];
            DIV, DIVU:           calc_res = quo_fin;
            default:             calc_res = rem_fin;
        endcase
    end

    always_comb begin
        res_d   = res_q;
        flags_d = flags_q;
        if (accept && special) begin
            res_d   = fast_res;
            flags_d = {dbz, ovf, fast_res[SIZE-1], fast_res == '0};
        end else if (finish) begin
            res_d   = calc_res;
            flags_d = {2'b00, calc_res[SIZE-1], calc_res == '0};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if (cnt_q == CNT_W'(SIZE-1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            flags_q <= 4'b0001;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            mcand_q <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            if (accept) begin
                cnt_q   <= '0;
                f3_q    <= funct3;
                neg_q   <= a_neg ^ b_neg;
                rneg_q  <= a_neg;
                mcand_q <= {{SIZE{1'b0}}, a_mag};
                mplr_q  <= b_mag;
                prod_q  <= '0;
            end else if (state_q == CALC) begin
                cnt_q   <= cnt_q + CNT_W'(1);
                prod_q  <= prod_nxt;
                mcand_q <= mcand_q << 1;
                mplr_q  <= mplr_q >> 1;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) && !flush;
    assign res       = res_q;
    assign alu_flags = flags_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed SIZE=64 scenarios plus randomized SIZE=8 and SIZE=64 runs
// checked against a wide-integer arithmetic reference model.
module tb_alu_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start64, flush64, busy64, done64;
    logic [63:0] a64, b64, res64;
    logic [2:0]  f64;
    logic [3:0]  fl64;
    logic        start8, flush8, busy8, done8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  f8;
    logic [3:0]  fl8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.SIZE(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .flush(flush64), .s1(a64), .s2(b64),
        .funct3(f64), .busy(busy64), .done(done64), .res(res64), .alu_flags(fl64)
    );

    alu_muldiv #(.SIZE(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .flush(flush8), .s1(a8), .s2(b8),
        .funct3(f8), .busy(busy8), .done(done8), .res(res8), .alu_flags(fl8)
    );

    // Reference: plain wide-integer RISC-V M semantics at width n; returns {flags, result}.
    function automatic logic [67:0] model(input int n, input logic [2:0] f3,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [129:0] mask, ua, ub;
        logic signed [129:0] sa, sb, r;
        logic [63:0] rr;
        logic dbz, ovf;
        mask = (130'd1 << n) - 130'd1;
        ua = {66'd0, a} & mask;
        ub = {66'd0, b} & mask;
        sa = ua;
        sb = ub;
        if (ua[n-1]) sa = sa - (130'sd1 <<< n);
        if (ub[n-1]) sb = sb - (130'sd1 <<< n);
        dbz = f3[2] && (ub == 0);
        ovf = ((f3 == DIV) || (f3 == REM)) && (ua == (130'd1 << (n-1))) && (ub == mask);
        case (f3)
            MUL:     r = $signed(ua * ub);
            MULH:    r = (sa * sb) >>> n;
            MULHSU:  r = (sa * $signed(ub)) >>> n;
            MULHU:   r = $signed((ua * ub) >> n);
            DIV:     r = dbz ? $signed(mask) : sa / sb;
            DIVU:    r = dbz ? $signed(mask) : $signed(ua / ub);
            REM:     r = dbz ? sa : sa % sb;
            default: r = dbz ? $signed(ua) : $signed(ua % ub);
        endcase
        rr = r[63:0] & mask[63:0];
        return {dbz, ovf, rr[n-1], rr == 64'd0, rr};
    endfunction

    task automatic run64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                         output int lat);
        @(negedge clk);
        f64 = f; a64 = a; b64 = b; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; f64 = 3'($urandom);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done64) begin lat = k; break; end
        end
    endtask

    task automatic run8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        @(negedge clk);
        f8 = f; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); f8 = 3'($urandom);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done8) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start64 = 1'b1; start8 = 1'b1; flush64 = 1'b0; flush8 = 1'b0;
        f64 = MUL; a64 = 64'd3; b64 = 64'd5; f8 = MUL; a8 = 8'd3; b8 = 8'd5;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; start64 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL reset_busy64: got %b want 0", busy64); end
        checks++; if (done64 !== 1'b0) begin errors++; $display("FAIL reset_done64: got %b want 0", done64); end
        checks++; if (res64 !== 64'd0) begin errors++; $display("FAIL reset_res64: got %h want 0", res64); end
        checks++; if (fl64 !== 4'b0001) begin errors++; $display("FAIL reset_flags64: got %b want 0001", fl64); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        checks++; if (fl8 !== 4'b0001) begin errors++; $display("FAIL reset_flags8: got %b want 0001", fl8); end
    endtask

    task automatic test_mul;
        int lat;
        run64(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat);
        checks++; if (lat !== 65) begin errors++; $display("FAIL mul_latency: got %0d want 65", lat); end
        checks++; if (res64 !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_res: got %h want ffffffffffffffeb", res64); end
        checks++; if (fl64 !== 4'b0010) begin errors++; $display("FAIL mul_flags: got %b want 0010", fl64); end
        run64(MULHU, '1, '1, lat);
        checks++; if (res64 !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulhu_res: got %h want fffffffffffffffe", res64); end
        checks++; if (fl64 !== 4'b0010) begin errors++; $display("FAIL mulhu_flags: got %b want 0010", fl64); end
    endtask

    task automatic test_div;
        int lat;
        run64(DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
        checks++; if (lat !== 65) begin errors++; $display("FAIL div_latency: got %0d want 65", lat); end
        checks++; if (res64 !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_res: got %h want fffffffffffffffd", res64); end
        run64(REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
        checks++; if (res64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_res: got %h want ffffffffffffffff", res64); end
        run64(DIVU, 64'd100, 64'd7, lat);
        checks++; if (res64 !== 64'd14) begin errors++; $display("FAIL divu_res: got %h want e", res64); end
        checks++; if (fl64 !== 4'b0000) begin errors++; $display("FAIL divu_flags: got %b want 0000", fl64); end
    endtask

    task automatic test_special;
        int lat;
        run64(DIVU, 64'd5, 64'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        checks++; if (res64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dbz_divu_res: got %h want all ones", res64); end
        checks++; if (fl64 !== 4'b1010) begin errors++; $display("FAIL dbz_divu_flags: got %b want 1010", fl64); end
        run64(REMU, 64'd5, 64'd0, lat);
        checks++; if (res64 !== 64'd5) begin errors++; $display("FAIL dbz_remu_res: got %h want 5", res64); end
        checks++; if (fl64 !== 4'b1000) begin errors++; $display("FAIL dbz_remu_flags: got %b want 1000", fl64); end
        run64(DIV, 64'h8000_0000_0000_0000, '1, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_latency: got %0d want 1", lat); end
        checks++; if (res64 !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_div_res: got %h want 8000000000000000", res64); end
        checks++; if (fl64 !== 4'b0110) begin errors++; $display("FAIL ovf_div_flags: got %b want 0110", fl64); end
        run64(REM, 64'h8000_0000_0000_0000, '1, lat);
        checks++; if (res64 !== 64'd0) begin errors++; $display("FAIL ovf_rem_res: got %h want 0", res64); end
        checks++; if (fl64 !== 4'b0101) begin errors++; $display("FAIL ovf_rem_flags: got %b want 0101", fl64); end
    endtask

    task automatic test_flush;
        int lat;
        int ndone = 0;
        run64(DIVU, 64'd100, 64'd7, lat);
        @(negedge clk);
        f64 = MUL; a64 = 64'd3; b64 = 64'd5; start64 = 1'b1;
        @(posedge clk); #1 start64 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done64) ndone++;
        end
        flush64 = 1'b1;
        @(negedge clk);
        flush64 = 1'b0;
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL flush_idle: busy got %b want 0", busy64); end
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done64) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", ndone); end
        checks++; if (res64 !== 64'd14) begin errors++; $display("FAIL flush_res_held: got %h want e", res64); end
        @(negedge clk);
        f64 = MUL; a64 = 64'd3; b64 = 64'd5; start64 = 1'b1; flush64 = 1'b1;
        @(posedge clk); #1 start64 = 1'b0; flush64 = 1'b0;
        @(negedge clk);
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL flush_beats_start: busy got %b want 0", busy64); end
    endtask

    task automatic test_back_to_back;
        int lat = -1;
        @(negedge clk);
        f64 = MUL; a64 = 64'd3; b64 = 64'd5; start64 = 1'b1;
        @(posedge clk); #1 start64 = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done64) begin lat = k; break; end
            if (k == 5) begin f64 = DIVU; a64 = 64'd100; b64 = 64'd7; start64 = 1'b1; end
            if (k == 6) start64 = 1'b0;
        end
        checks++; if (lat !== 65) begin errors++; $display("FAIL ignore_start_latency: got %0d want 65", lat); end
        checks++; if (res64 !== 64'd15) begin errors++; $display("FAIL ignore_start_res: got %h want f", res64); end
        f64 = DIVU; a64 = 64'd100; b64 = 64'd7; start64 = 1'b1;
        @(negedge clk);
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL start_in_done: busy got %b want 0", busy64); end
        @(posedge clk); #1 start64 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done64) begin lat = k; break; end
        end
        checks++; if (lat !== 65) begin errors++; $display("FAIL b2b_latency: got %0d want 65", lat); end
        checks++; if (res64 !== 64'd14) begin errors++; $display("FAIL b2b_res: got %h want e", res64); end
    endtask

    task automatic test_random8;
        int lat;
        logic [2:0] f;
        logic [7:0] a, b;
        logic [67:0] exp;
        for (int i = 0; i < 400; i++) begin
            f = 3'($urandom_range(0, 7));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0: b = 8'h00;
                1: begin a = 8'h80; b = 8'hFF; end
                default: ;
            endcase
            exp = model(8, f, {56'd0, a}, {56'd0, b});
            run8(f, a, b, lat);
            checks++; if (res8 !== exp[7:0]) begin errors++; $display("FAIL rand8_res f3=%b a=%h b=%h: got %h want %h", f, a, b, res8, exp[7:0]); end
            checks++; if (fl8 !== exp[67:64]) begin errors++; $display("FAIL rand8_flags f3=%b a=%h b=%h: got %b want %b", f, a, b, fl8, exp[67:64]); end
            checks++; if (lat !== ((exp[67] | exp[66]) ? 1 : 9)) begin errors++; $display("FAIL rand8_latency f3=%b a=%h b=%h: got %0d", f, a, b, lat); end
        end
    endtask

    task automatic test_random64;
        int lat;
        logic [2:0] f;
        logic [63:0] a, b;
        logic [67:0] exp;
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 1) b = b >> $urandom_range(1, 60);
            exp = model(64, f, a, b);
            run64(f, a, b, lat);
            checks++; if (res64 !== exp[63:0]) begin errors++; $display("FAIL rand64_res f3=%b a=%h b=%h: got %h want %h", f, a, b, res64, exp[63:0]); end
            checks++; if (fl64 !== exp[67:64]) begin errors++; $display("FAIL rand64_flags f3=%b: got %b want %b", f, fl64, exp[67:64]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_random8();
        test_random64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
